serial_led_driver: RTL

SERIAL_LED_DRIVER -- requirements
Module: serial_led_driver

---
 rtl/led_drv_pkg.sv | 14 +
 rtl/clk_phase_div.sv | 32 +++
 rtl/serial_led_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/led_drv_pkg.sv
// Shared constants for the serial LED driver: default parameters and FSM encoding.
package led_drv_pkg;

   localparam int DEF_DATA_BITS = 16;
   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_DIR       = 0;
   localparam int DEF_INVERT    = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

endpackage

// File: rtl/clk_phase_div.sv
// sclk phase divider: o_tick marks the last clk cycle of each CLK_DIV-cycle phase,
// o_tick_nxt predicts it one cycle ahead so the top can register its outputs.
module clk_phase_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   output logic o_tick,
   output logic o_tick_nxt
);

   localparam int              CW   = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (i_clr || (r_cnt == LAST)) w_cnt_nxt = '0;
   end

   assign o_tick     = (r_cnt == LAST);
   assign o_tick_nxt = (w_cnt_nxt == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_cnt <= '0;
      else       r_cnt <= w_cnt_nxt;
   end

endmodule

// File: rtl/serial_led_driver.sv
// Serial LED shift-register driver: CLEAR, DATA_BITS sclk-framed bits, LATCH pulse.
// Every output is a flop fed from the next-state decode, so nothing glitches.
module serial_led_driver
   import led_drv_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int DIR       = DEF_DIR,
   parameter int INVERT    = DEF_INVERT
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] pdata,
   output logic                 sclk,
   output logic                 sout,
   output logic                 sclrn,
   output logic                 en,
   output logic                 busy,
   output logic                 done
);

   localparam int            BW       = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic          INV      = (INVERT != 0);

   logic                 r_start_q, r_pend, r_phase;
   logic [1:0]           r_state;
   logic [DATA_BITS-1:0] r_shreg;
   logic [BW-1:0]        r_bitcnt;
   logic                 r_sclk, r_sout, r_sclrn, r_en, r_busy, r_done;

   logic                 w_edge, w_tick, w_tick_nxt, w_done_cyc, w_launch, w_bit_nxt;
   logic                 w_pend_nxt, w_phase_nxt;
   logic [1:0]           w_state_nxt;
   logic [DATA_BITS-1:0] w_shreg_nxt;
   logic [BW-1:0]        w_bitcnt_nxt;

   assign w_edge     = start & ~r_start_q;
   assign w_done_cyc = (r_state == ST_LATCH) && w_tick;
   // An edge landing on the done cycle relaunches just like a pending one.
   assign w_launch   = ((r_state == ST_IDLE) && w_edge) || (w_done_cyc && (r_pend || w_edge));

   clk_phase_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk        (clk),
      .rstn       (rstn),
      .i_clr      (w_launch),
      .o_tick     (w_tick),
      .o_tick_nxt (w_tick_nxt)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_phase_nxt  = r_phase;
      w_bitcnt_nxt = r_bitcnt;
      w_pend_nxt   = r_pend;
      if (w_edge && (r_state != ST_IDLE)) w_pend_nxt = 1'b1;
      case (r_state)
         ST_CLEAR: if (w_tick) begin
            w_state_nxt  = ST_SHIFT;
            w_phase_nxt  = 1'b0;
            w_bitcnt_nxt = '0;
         end
         ST_SHIFT: if (w_tick) begin
            if (!r_phase) begin
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt = 1'b0;
               w_shreg_nxt = (DIR != 0) ? (r_shreg >> 1) : (r_shreg << 1);
               if (r_bitcnt == LAST_BIT) w_state_nxt  = ST_LATCH;
               else                      w_bitcnt_nxt = r_bitcnt + BW'(1);
            end
         end
         ST_LATCH: if (w_tick) w_state_nxt = ST_IDLE;
         default: ;
      endcase
      if (w_launch) begin
         w_state_nxt = ST_CLEAR;
         w_shreg_nxt = pdata;
         w_pend_nxt  = 1'b0;
      end
   end

   assign w_bit_nxt = (DIR != 0) ? w_shreg_nxt[0] : w_shreg_nxt[DATA_BITS-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_start_q <= 1'b1;
         r_state   <= ST_IDLE;
         r_shreg   <= '0;
         r_phase   <= 1'b0;
         r_bitcnt  <= '0;
         r_pend    <= 1'b0;
         r_sclk    <= 1'b0;
         r_sout    <= INV;
         r_sclrn   <= 1'b1;
         r_en      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_start_q <= start;
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_phase   <= w_phase_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_pend    <= w_pend_nxt;
         r_sclk    <= (w_state_nxt == ST_SHIFT) && w_phase_nxt;
         r_sout    <= INV ^ ((w_state_nxt == ST_SHIFT) && w_bit_nxt);
         r_sclrn   <= (w_state_nxt != ST_CLEAR);
         r_en      <= (w_state_nxt == ST_LATCH);
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (w_state_nxt == ST_LATCH) && w_tick_nxt;
      end
   end

   assign sclk  = r_sclk;
   assign sout  = r_sout;
   assign sclrn = r_sclrn;
   assign en    = r_en;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
